// File: rtl/sensor_frame_rx_pkg.sv
// Shared types and constants for the sensor frame receiver.
package sensor_frame_rx_pkg;

  // Frame parser states, in byte order of the frame.
  typedef enum logic [2:0] {
    HUNT = 3'd0,
    RAIN = 3'd1,
    SEIS = 3'd2,
    WIND = 3'd3,
    SEA  = 3'd4,
    CSUM = 3'd5
  } state_t;

  // Error causes reported alongside the err pulse.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_RANGE   = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Decoded field widths; these feed the disaster classifier unchanged.
  localparam int RAIN_W = 7;
  localparam int SEIS_W = 5;
  localparam int WIND_W = 7;
  localparam int SEA_W  = 7;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

endpackage

// File: rtl/sensor_frame_rx_timeout.sv
// Inter-byte idle timer. Counts enabled cycles since the last clear and
// pulses expired on the enabled cycle that brings the count to TIMEOUT_CYCLES.
module frame_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Firing on the last enabled cycle lets the FSM leave on that same edge;
  // a byte in that cycle drops enable, so the byte wins.
  assign expired = enable && (count == LAST);

  // Idle count register; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sensor_frame_rx.sv
// Sensor frame receiver: HEADER, rain, seismic, wind, sea, csum (XOR of
// payload). Validates range and checksum and publishes the fields.
//
//   state | meaning
//   HUNT  | waiting for HEADER, other bytes dropped silently
//   RAIN  | expecting rain byte
//   SEIS  | expecting seismic byte
//   WIND  | expecting wind byte
//   SEA   | expecting sea-level byte
//   CSUM  | expecting checksum byte
module sensor_frame_rx
  import sensor_frame_rx_pkg::*;
#(
  parameter logic [7:0]  HEADER         = HEADER_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic [RAIN_W-1:0] rain,
  output logic [SEIS_W-1:0] seismic,
  output logic [WIND_W-1:0] wind,
  output logic [SEA_W-1:0]  sea,
  output logic              out_valid,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              have_data
);

  state_t state_q, state_d;
  logic [7:0] xor_q, xor_d;

  logic [RAIN_W-1:0] stage_rain;
  logic [SEIS_W-1:0] stage_seis;
  logic [WIND_W-1:0] stage_wind;
  logic [SEA_W-1:0]  stage_sea;

  logic ld_rain, ld_seis, ld_wind, ld_sea;
  logic csum_ok, fail;
  logic [1:0] fail_code;
  logic expired;

  frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (in_valid || (state_q == HUNT)),
    .enable (!in_valid && (state_q != HUNT)),
    .expired(expired)
  );

  // Next-state, checksum accumulation and per-byte decisions.
  always_comb begin
    state_d   = state_q;
    xor_d     = xor_q;
    ld_rain   = 1'b0;
    ld_seis   = 1'b0;
    ld_wind   = 1'b0;
    ld_sea    = 1'b0;
    csum_ok   = 1'b0;
    fail      = 1'b0;
    fail_code = ERR_NONE;
    case (state_q)
      HUNT: begin
        if (in_valid && (in_data == HEADER)) begin
          state_d = RAIN;
          xor_d   = '0;
        end
      end
      RAIN: begin
        if (in_valid) begin
          if (in_data[7]) begin
            fail = 1'b1; fail_code = ERR_RANGE; state_d = HUNT;
          end else begin
            ld_rain = 1'b1; xor_d = xor_q ^ in_data; state_d = SEIS;
          end
        end
      end
      SEIS: begin
        if (in_valid) begin
          if (in_data[7:5] != 3'b000) begin
            fail = 1'b1; fail_code = ERR_RANGE; state_d = HUNT;
          end else begin
            ld_seis = 1'b1; xor_d = xor_q ^ in_data; state_d = WIND;
          end
        end
      end
      WIND: begin
        if (in_valid) begin
          if (in_data[7]) begin
            fail = 1'b1; fail_code = ERR_RANGE; state_d = HUNT;
          end else begin
            ld_wind = 1'b1; xor_d = xor_q ^ in_data; state_d = SEA;
          end
        end
      end
      SEA: begin
        if (in_valid) begin
          if (in_data[7]) begin
            fail = 1'b1; fail_code = ERR_RANGE; state_d = HUNT;
          end else begin
            ld_sea = 1'b1; xor_d = xor_q ^ in_data; state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (in_valid) begin
          state_d = HUNT;
          if (in_data == xor_q) begin
            csum_ok = 1'b1;
          end else begin
            fail = 1'b1; fail_code = ERR_CSUM;
          end
        end
      end
      default: state_d = HUNT;
    endcase
    // expired implies no byte this cycle, so it never collides with the above.
    if (expired) begin
      state_d   = HUNT;
      fail      = 1'b1;
      fail_code = ERR_TIMEOUT;
    end
  end

  // State, checksum, staging and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      xor_q      <= '0;
      stage_rain <= '0;
      stage_seis <= '0;
      stage_wind <= '0;
      stage_sea  <= '0;
      rain       <= '0;
      seismic    <= '0;
      wind       <= '0;
      sea        <= '0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      have_data  <= 1'b0;
    end else begin
      state_q <= state_d;
      xor_q   <= xor_d;
      if (ld_rain) stage_rain <= in_data[RAIN_W-1:0];
      if (ld_seis) stage_seis <= in_data[SEIS_W-1:0];
      if (ld_wind) stage_wind <= in_data[WIND_W-1:0];
      if (ld_sea)  stage_sea  <= in_data[SEA_W-1:0];
      if (csum_ok) begin
        rain      <= stage_rain;
        seismic   <= stage_seis;
        wind      <= stage_wind;
        sea       <= stage_sea;
        have_data <= 1'b1;
      end
      out_valid <= csum_ok;
      err       <= fail;
      err_code  <= fail ? fail_code : ERR_NONE;
    end
  end

endmodule

// File: tb/tb_sensor_frame_rx.sv
// Self-checking bench for sensor_frame_rx with TIMEOUT_CYCLES = 8.
module tb_sensor_frame_rx;
  import sensor_frame_rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [6:0] rain;
  logic [4:0] seismic;
  logic [6:0] wind;
  logic [6:0] sea;
  logic       out_valid;
  logic       err;
  logic [1:0] err_code;
  logic       have_data;

  sensor_frame_rx #(
    .HEADER        (8'hA5),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .rain     (rain),
    .seismic  (seismic),
    .wind     (wind),
    .sea      (sea),
    .out_valid(out_valid),
    .err      (err),
    .err_code (err_code),
    .have_data(have_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       ov;
    logic       er;
    logic [1:0] ec;
    logic [6:0] f_rain;
    logic [4:0] f_seis;
    logic [6:0] f_wind;
    logic [6:0] f_sea;
  } vec_t;

  typedef struct {
    logic       ov;
    logic       er;
    logic [1:0] ec;
    logic [6:0] rain;
    logic [4:0] seis;
    logic [6:0] wind;
    logic [6:0] sea;
    logic       hd;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_step = 0;

  logic [6:0] m_rain = '0;
  logic [4:0] m_seis = '0;
  logic [6:0] m_wind = '0;
  logic [6:0] m_sea  = '0;
  logic       m_hd   = 1'b0;

  task automatic add(input logic r, input logic v, input logic [7:0] d,
                     input logic ov, input logic er, input logic [1:0] ec,
                     input logic [6:0] fr, input logic [4:0] fs,
                     input logic [6:0] fw, input logic [6:0] fsea);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.ov = ov; t.er = er; t.ec = ec;
    t.f_rain = fr; t.f_seis = fs; t.f_wind = fw; t.f_sea = fsea;
    vecs.push_back(t);
  endtask

  task automatic byt(input logic [7:0] d);
    add(1'b0, 1'b1, d, 1'b0, 1'b0, 2'b00, 7'd0, 5'd0, 7'd0, 7'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 7'd0, 5'd0, 7'd0, 7'd0);
  endtask

  task automatic good(input logic [7:0] d, input logic [6:0] fr, input logic [4:0] fs,
                      input logic [6:0] fw, input logic [6:0] fsea);
    add(1'b0, 1'b1, d, 1'b1, 1'b0, 2'b00, fr, fs, fw, fsea);
  endtask

  task automatic bad(input logic v, input logic [7:0] d, input logic [1:0] ec);
    add(1'b0, v, d, 1'b0, 1'b1, ec, 7'd0, 5'd0, 7'd0, 7'd0);
  endtask

  task automatic do_rst();
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 7'd0, 5'd0, 7'd0, 7'd0);
  endtask

  // Pop the scoreboard and compare against the DUT after the edge.
  task automatic check();
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty at step %0d", n_step);
      return;
    end
    e = sb.pop_front();
    if (out_valid !== e.ov || err !== e.er || (e.er && err_code !== e.ec)) begin
      n_bad++;
      $display("FAIL ctl step %0d: got ov=%b err=%b code=%b, want ov=%b err=%b code=%b",
               n_step, out_valid, err, err_code, e.ov, e.er, e.ec);
    end
    n_cmp++;
    if (rain !== e.rain || seismic !== e.seis || wind !== e.wind || sea !== e.sea ||
        have_data !== e.hd) begin
      n_bad++;
      $display("FAIL data step %0d: got %0d/%0d/%0d/%0d hd=%b, want %0d/%0d/%0d/%0d hd=%b",
               n_step, rain, seismic, wind, sea, have_data,
               e.rain, e.seis, e.wind, e.sea, e.hd);
    end
  endtask

  task automatic step(input vec_t t);
    exp_t e;
    rst      = t.r;
    in_valid = t.v;
    in_data  = t.d;
    if (t.r) begin
      m_rain = '0; m_seis = '0; m_wind = '0; m_sea = '0; m_hd = 1'b0;
    end else if (t.ov) begin
      m_rain = t.f_rain; m_seis = t.f_seis; m_wind = t.f_wind; m_sea = t.f_sea;
      m_hd = 1'b1;
    end
    e.ov = t.ov; e.er = t.er; e.ec = t.ec;
    e.rain = m_rain; e.seis = m_seis; e.wind = m_wind; e.sea = m_sea; e.hd = m_hd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_step++;
    check();
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    // Reset, junk before header, then the reference frame.
    do_rst(); do_rst();
    byt(8'h00); byt(8'hFF);
    byt(8'hA5); byt(8'h1E); byt(8'h0F); byt(8'h3C); byt(8'h32);
    good(8'h1F, 7'd30, 5'd15, 7'd60, 7'd50);
    idle(1);
    // Rain range error, then a normal frame is accepted.
    byt(8'hA5); bad(1'b1, 8'h80, ERR_RANGE);
    byt(8'hA5); byt(8'h05); byt(8'h1F); byt(8'h7F); byt(8'h00);
    good(8'h65, 7'd5, 5'd31, 7'd127, 7'd0);
    // Seismic reserved bit, header value inside frame is data (no resync).
    byt(8'hA5); byt(8'h01); bad(1'b1, 8'h20, ERR_RANGE);
    byt(8'hA5); byt(8'h1E); bad(1'b1, 8'hA5, ERR_RANGE);
    // Checksum mismatch keeps previous outputs.
    byt(8'hA5); byt(8'h1E); byt(8'h0F); byt(8'h3C); byt(8'h32);
    bad(1'b1, 8'h00, ERR_CSUM);
    idle(1);
    // Frame with short gaps between bytes.
    byt(8'hA5); idle(2); byt(8'h1E); idle(3); byt(8'h0F); byt(8'h3C); idle(7);
    byt(8'h32); good(8'h1F, 7'd30, 5'd15, 7'd60, 7'd50);
    // Wind and sea range errors.
    byt(8'hA5); byt(8'h00); byt(8'h00); bad(1'b1, 8'h80, ERR_RANGE);
    byt(8'hA5); byt(8'h00); byt(8'h00); byt(8'h00); bad(1'b1, 8'hFF, ERR_RANGE);
    // All-zero and all-max payloads.
    byt(8'hA5); byt(8'h00); byt(8'h00); byt(8'h00); byt(8'h00);
    good(8'h00, 7'd0, 5'd0, 7'd0, 7'd0);
    byt(8'hA5); byt(8'h7F); byt(8'h1F); byt(8'h7F); byt(8'h7F);
    good(8'h60, 7'd127, 5'd31, 7'd127, 7'd127);
    run_vecs();

    // Timeout: eight idle cycles after a payload byte.
    byt(8'hA5); byt(8'h1E); idle(7); bad(1'b0, 8'h00, ERR_TIMEOUT);
    idle(1); byt(8'h0F); idle(1);
    // Byte on the eighth cycle wins; frame completes.
    byt(8'hA5); byt(8'h1E); idle(7); byt(8'h0F); byt(8'h3C); byt(8'h32);
    good(8'h1F, 7'd30, 5'd15, 7'd60, 7'd50);
    // Timeout while waiting for the checksum.
    byt(8'hA5); byt(8'h01); byt(8'h02); byt(8'h03); byt(8'h04);
    idle(7); bad(1'b0, 8'h00, ERR_TIMEOUT); idle(1);
    run_vecs();

    // Reset mid-frame discards silently; next frame decodes normally.
    byt(8'hA5); byt(8'h1E); byt(8'h0F);
    do_rst(); idle(2);
    byt(8'hA5); byt(8'h1E); byt(8'h0F); byt(8'h3C); byt(8'h32);
    good(8'h1F, 7'd30, 5'd15, 7'd60, 7'd50);
    idle(1);
    run_vecs();

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sensor_frame_rx.md
SENSOR_FRAME_RX -- requirements
Module: sensor_frame_rx

Interface
REQ-001 The block SHALL have parameter HEADER, default 8'hA5: frame start byte.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000: maximum idle cycles between bytes inside a frame; legal range 1..65535.
REQ-003 The block SHALL have the following ports, with clk and rst first; one clock; reset is synchronous and active-high:
- clk  input  1  sole clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data carries a byte this cycle
- in_data  input  8  received byte
- rain  output  7  last good rain reading, 0..127
- seismic  output  5  last good seismic reading, scaled 0..31
- wind  output  7  last good wind reading, 0..127
- sea  output  7  last good sea-level reading, 0..127
- out_valid  output  1  one-cycle pulse when the four fields update
- err  output  1  one-cycle pulse when a frame is discarded
- err_code  output  2  error cause, valid while err=1: 01 range, 10 checksum, 11 timeout
- have_data  output  1  high once at least one good frame has been received since reset

Function
REQ-004 The frame SHALL be six bytes: HEADER, rain, seismic, wind, sea, csum, where csum = XOR of the four payload bytes.
REQ-005 The block SHALL accept a byte on every cycle with in_valid=1 and SHALL have no backpressure.
REQ-006 The FSM SHALL use the states HUNT, RAIN, SEIS, WIND, SEA and CSUM.
REQ-007 In HUNT, a byte equal to HEADER SHALL move the FSM to RAIN; any other byte SHALL be dropped silently, with no err.
REQ-008 Each accepted byte SHALL advance the FSM RAIN->SEIS->WIND->SEA->CSUM->HUNT; a HEADER value inside a frame SHALL be treated as data (no resync).
REQ-009 A payload byte with nonzero reserved bits SHALL be a range error: rain/wind/sea bit 7, or seismic bits 7:5.
REQ-010 On a range error, the FSM SHALL return to HUNT immediately, and err=1 with err_code=01 the next cycle.
REQ-011 The running XOR SHALL be cleared on HEADER acceptance and SHALL accumulate the payload bytes.
REQ-012 In CSUM, a match SHALL load rain/seismic/wind/sea from the staged payload, pulse out_valid and set have_data, all in the cycle after the csum byte (latency 1).
REQ-013 In CSUM, a mismatch SHALL leave the outputs unchanged and pulse err with err_code=10 in the cycle after the csum byte.
REQ-014 Outside HUNT, an idle counter SHALL count cycles with in_valid=0 and SHALL clear on every accepted byte.
REQ-015 When the idle counter reaches TIMEOUT_CYCLES, the FSM SHALL go to HUNT and pulse err with err_code=11 the next cycle.
REQ-016 If a byte arrives on the cycle the timeout would fire, the byte SHALL win and no timeout SHALL occur.
REQ-017 The payload SHALL be staged in internal registers; rain/seismic/wind/sea SHALL change only on a good checksum and SHALL hold otherwise.
REQ-018 out_valid and err SHALL never be high in the same cycle.

Reset
REQ-019 rst SHALL force: FSM=HUNT; idle counter, XOR and staging registers=0; rain=seismic=wind=sea=0; out_valid=err=have_data=0; err_code=00.
REQ-020 rst asserted mid-frame SHALL discard the partial frame without an err pulse.
REQ-021 The first byte after rst deasserts SHALL be evaluated in HUNT.

Structure
REQ-022 The shared package SHALL hold: the FSM state enum, the err_code constants, the field widths (7/5/7/7), and the default HEADER value.
REQ-023 A sub-module frame_timeout SHALL implement the idle counter (inputs: clear, enable; output: expired pulse), with counter width = clog2(TIMEOUT_CYCLES+1).
REQ-024 The decoded fields SHALL directly drive the disaster classifier inputs of the same widths.

Verification
REQ-025 Bytes A5,1E,0F,3C,32,1F -> one cycle after 1F: out_valid=1, rain=30, seismic=15, wind=60, sea=50, have_data=1.
REQ-026 Bytes 00,FF, then the REQ-025 frame -> no err for 00 or FF; outputs as in REQ-025.
REQ-027 Bytes A5,80 -> err=1, err_code=01 the next cycle; a following valid frame is then accepted normally.
REQ-028 Bytes A5,1E,0F,3C,32,00 -> err=1, err_code=10; outputs unchanged from the previous good frame.
REQ-029 With TIMEOUT_CYCLES=8: bytes A5,1E, then 8 idle cycles -> err=1, err_code=11. A variant with the next byte arriving on the 8th idle cycle -> no err, and the frame continues.
REQ-030 rst pulsed after A5,1E,0F -> all outputs 0 and no err; then the full REQ-025 frame -> out_valid=1 with the REQ-025 values.
